// File: rtl/gcd_pkg.sv
// Shared types and constants for the iterative GCD unit.
// Holds the controller state encoding and the default operand width.
package gcd_pkg;

    localparam int unsigned GCD_NBITS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_e;

endpackage

// File: rtl/gcd_req_queue.sv
// Two-entry request buffer with val/rdy handshakes on both sides.
// Decouples the upstream source from the GCD controller.
module gcd_req_queue #(
    parameter int unsigned W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_enq_val,
    output logic         o_enq_rdy,
    input  logic [W-1:0] i_enq_msg,
    output logic         o_deq_val,
    input  logic         i_deq_rdy,
    output logic [W-1:0] o_deq_msg
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_enq;
    logic         w_deq;

    assign o_enq_rdy = (r_count != 2'd2);
    assign o_deq_val = (r_count != 2'd0);
    assign o_deq_msg = r_mem[r_rd_ptr];
    assign w_enq     = i_enq_val && o_enq_rdy;
    assign w_deq     = o_deq_val && i_deq_rdy;

    always_ff @(posedge i_clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= i_enq_msg;
        end
    end

    // One-bit pointers wrap 1->0 by simple inversion.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_deq) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            unique case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/gcd_iter_unit.sv
// Iterative GCD by repeated subtraction and swap, one step per cycle.
// Requests are buffered in a 2-entry queue; responses return in order.
module gcd_iter_unit
    import gcd_pkg::*;
#(
    parameter int unsigned p_nbits = GCD_NBITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_val,
    output logic                 req_rdy,
    input  logic [2*p_nbits-1:0] req_msg,
    output logic                 resp_val,
    input  logic                 resp_rdy,
    output logic [p_nbits-1:0]   resp_msg
);

    logic                 w_q_val;
    logic                 w_q_rdy;
    logic [2*p_nbits-1:0] w_q_msg;
    gcd_state_e           r_state;
    gcd_state_e           w_next_state;
    logic [p_nbits-1:0]   r_a;
    logic [p_nbits-1:0]   r_b;
    logic                 w_a_lt_b;
    logic                 w_b_zero;
    logic [p_nbits-1:0]   w_diff;
    logic                 w_load;

    gcd_req_queue #(
        .W (2*p_nbits)
    ) u_req_queue (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_enq_val (req_val),
        .o_enq_rdy (req_rdy),
        .i_enq_msg (req_msg),
        .o_deq_val (w_q_val),
        .i_deq_rdy (w_q_rdy),
        .o_deq_msg (w_q_msg)
    );

    assign w_a_lt_b = (r_a < r_b);
    assign w_b_zero = (r_b == '0);
    assign w_diff   = r_a - r_b;
    assign w_load   = w_q_val && w_q_rdy;

    always_comb begin
        w_next_state = r_state;
        w_q_rdy      = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_q_rdy = 1'b1;
                if (w_q_val) begin
                    w_next_state = CALC;
                end
            end
            CALC: begin
                if (!w_a_lt_b && w_b_zero) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (resp_rdy) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The swap has priority, so the subtract only runs with A >= B.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a <= '0;
            r_b <= '0;
        end else if (w_load) begin
            r_a <= w_q_msg[2*p_nbits-1:p_nbits];
            r_b <= w_q_msg[p_nbits-1:0];
        end else if (r_state == CALC) begin
            if (w_a_lt_b) begin
                r_a <= r_b;
                r_b <= r_a;
            end else if (!w_b_zero) begin
                r_a <= w_diff;
            end
        end
    end

    assign resp_val = (r_state == DONE);
    assign resp_msg = resp_val ? r_a : '0;

endmodule
